// File: rtl/ser_pkg.sv
// Shared types and helpers for the FIFO word serializer.
package ser_pkg;

   typedef enum logic {IDLE, SEND} ser_state_t;

   localparam int unsigned WORD_CNT_W = 16;

   function automatic int unsigned beats(input int unsigned width, input int unsigned out_w);
      return width / out_w;
   endfunction

endpackage

// File: rtl/fifo_word_serializer.sv
// Pops words from a show-ahead FIFO and emits them as OUT_W-bit beats on a valid/ready stream.
// Optional SER_PARITY_EN adds an even-parity bit alongside each beat.
module fifo_word_serializer
   import ser_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned OUT_W     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  fifo_empty,
   input  logic [WIDTH-1:0]      fifo_data,
   output logic                  fifo_re,
   output logic                  ser_valid,
   output logic [OUT_W-1:0]      ser_data,
   output logic                  ser_last,
`ifdef SER_PARITY_EN
   output logic                  ser_parity,
`endif
   input  logic                  ser_ready,
   output logic                  busy,
   output logic [WORD_CNT_W-1:0] word_cnt
);

   localparam int unsigned     BEATS     = beats(WIDTH, OUT_W);
   localparam int unsigned     CNT_W     = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   generate
      if (((WIDTH % OUT_W) != 0) || (BEATS < 2)) begin : g_bad_cfg
         $error("fifo_word_serializer: WIDTH must be a multiple of OUT_W with at least 2 beats");
      end
   endgenerate

   ser_state_t            state_q, state_d;
   logic [WIDTH-1:0]      shift_q, shift_d;
   logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
   logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic                  on_last;

   assign on_last = (beat_cnt_q == LAST_BEAT);

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      beat_cnt_d = beat_cnt_q;
      word_cnt_d = word_cnt_q;
      fifo_re    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_re    = 1'b1;
               shift_d    = fifo_data;
               beat_cnt_d = '0;
               state_d    = SEND;
            end
         end
         SEND: begin
            if (ser_ready) begin
               if (!on_last) begin
                  shift_d    = MSB_FIRST ? (shift_q << OUT_W) : (shift_q >> OUT_W);
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end else begin
                  word_cnt_d = word_cnt_q + 1'b1;
                  // Reload in the same cycle as the last beat so words run back-to-back.
                  if (!fifo_empty) begin
                     fifo_re    = 1'b1;
                     shift_d    = fifo_data;
                     beat_cnt_d = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (!reset_n) begin
         fifo_re = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         beat_cnt_q <= '0;
         word_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         beat_cnt_q <= beat_cnt_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   assign ser_valid = (state_q == SEND);
   assign busy      = (state_q == SEND);
   assign ser_last  = (state_q == SEND) && on_last;
   assign ser_data  = MSB_FIRST ? shift_q[WIDTH-1 -: OUT_W] : shift_q[OUT_W-1:0];
   assign word_cnt  = word_cnt_q;

`ifdef SER_PARITY_EN
   assign ser_parity = ^ser_data;
`endif

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench for fifo_word_serializer: MSB-first instance plus an LSB-first instance.
module tb_fifo_word_serializer;

   typedef struct {
      logic        push;
      logic [31:0] word;
      logic        rst;
      logic        rdy;
      logic        re;
      logic        v;
      logic [7:0]  d;
      logic        l;
      logic        b;
      logic [15:0] c;
   } row_t;

   logic        clock;
   logic        reset_n;
   logic        fifo_empty;
   logic [31:0] fifo_data;
   logic        fifo_re;
   logic        ser_valid;
   logic [7:0]  ser_data;
   logic        ser_last;
   logic        ser_ready;
   logic        busy;
   logic [15:0] word_cnt;

   logic        fifo_empty2;
   logic [31:0] fifo_data2;
   logic        fifo_re2;
   logic        ser_valid2;
   logic [7:0]  ser_data2;
   logic        ser_last2;
   logic        ser_ready2;
   logic        busy2;
   logic [15:0] word_cnt2;
`ifdef SER_PARITY_EN
   logic        ser_parity;
   logic        ser_parity2;
`endif

   int          checks = 0;
   int          errors = 0;
   string       tag;
   logic [31:0] q[$];
   row_t        tbl[25];

   fifo_word_serializer #(.WIDTH(32), .OUT_W(8), .MSB_FIRST(1'b1)) u_dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_re    (fifo_re),
      .ser_valid  (ser_valid),
      .ser_data   (ser_data),
      .ser_last   (ser_last),
`ifdef SER_PARITY_EN
      .ser_parity (ser_parity),
`endif
      .ser_ready  (ser_ready),
      .busy       (busy),
      .word_cnt   (word_cnt)
   );

   fifo_word_serializer #(.WIDTH(32), .OUT_W(8), .MSB_FIRST(1'b0)) u_lsb (
      .clock      (clock),
      .reset_n    (reset_n),
      .fifo_empty (fifo_empty2),
      .fifo_data  (fifo_data2),
      .fifo_re    (fifo_re2),
      .ser_valid  (ser_valid2),
      .ser_data   (ser_data2),
      .ser_last   (ser_last2),
`ifdef SER_PARITY_EN
      .ser_parity (ser_parity2),
`endif
      .ser_ready  (ser_ready2),
      .busy       (busy2),
      .word_cnt   (word_cnt2)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
      end
   endtask

   // One cycle against the FIFO model: drive, compare at negedge, pop after the edge.
   task automatic run_row(input row_t r);
      logic re_s;
      if (r.push) q.push_back(r.word);
      reset_n    = r.rst;
      ser_ready  = r.rdy;
      fifo_empty = (q.size() == 0);
      fifo_data  = (q.size() != 0) ? q[0] : 32'h0;
      @(negedge clock);
      chk("fifo_re", {31'b0, fifo_re}, {31'b0, r.re});
      chk("ser_valid", {31'b0, ser_valid}, {31'b0, r.v});
      if (r.v) begin
         chk("ser_data", {24'b0, ser_data}, {24'b0, r.d});
         chk("ser_last", {31'b0, ser_last}, {31'b0, r.l});
      end
      chk("busy", {31'b0, busy}, {31'b0, r.b});
      chk("word_cnt", {16'b0, word_cnt}, {16'b0, r.c});
      re_s = fifo_re;
      @(posedge clock);
      #1;
      if (re_s && q.size() != 0) void'(q.pop_front());
   endtask

   function automatic row_t mk(input logic push, input logic [31:0] word, input logic rst,
                               input logic rdy, input logic re, input logic v, input logic [7:0] d,
                               input logic l, input logic b, input logic [15:0] c);
      row_t r;
      r.push = push; r.word = word; r.rst = rst; r.rdy = rdy; r.re = re;
      r.v = v; r.d = d; r.l = l; r.b = b; r.c = c;
      return r;
   endfunction

   initial begin
      logic [7:0] lsb_exp[4];
      reset_n     = 1'b0;
      ser_ready   = 1'b1;
      fifo_empty  = 1'b1;
      fifo_data   = '0;
      fifo_empty2 = 1'b1;
      fifo_data2  = '0;
      ser_ready2  = 1'b1;
      @(posedge clock);
      #1;

      // Reset held for 2 cycles with a word waiting: no pop, nothing valid.
      tag = "reset0";
      run_row(mk(1, 32'hDEADBEEF, 0, 1, 0, 0, 8'h00, 0, 0, 16'd0));
      tag = "reset1";
      run_row(mk(0, 32'h0,        0, 1, 0, 0, 8'h00, 0, 0, 16'd0));
      q.delete();

      // Single word, backpressure on B2, then two words back-to-back.
      tbl[0]  = mk(1, 32'hA1B2C3D4, 1, 1, 1, 0, 8'h00, 0, 0, 16'd0);
      tbl[1]  = mk(0, 32'h0,        1, 1, 0, 1, 8'hA1, 0, 1, 16'd0);
      tbl[2]  = mk(0, 32'h0,        1, 1, 0, 1, 8'hB2, 0, 1, 16'd0);
      tbl[3]  = mk(0, 32'h0,        1, 1, 0, 1, 8'hC3, 0, 1, 16'd0);
      tbl[4]  = mk(0, 32'h0,        1, 1, 0, 1, 8'hD4, 1, 1, 16'd0);
      tbl[5]  = mk(0, 32'h0,        1, 1, 0, 0, 8'h00, 0, 0, 16'd1);
      tbl[6]  = mk(1, 32'hA1B2C3D4, 1, 1, 1, 0, 8'h00, 0, 0, 16'd1);
      tbl[7]  = mk(0, 32'h0,        1, 1, 0, 1, 8'hA1, 0, 1, 16'd1);
      tbl[8]  = mk(0, 32'h0,        1, 0, 0, 1, 8'hB2, 0, 1, 16'd1);
      tbl[9]  = mk(0, 32'h0,        1, 0, 0, 1, 8'hB2, 0, 1, 16'd1);
      tbl[10] = mk(0, 32'h0,        1, 0, 0, 1, 8'hB2, 0, 1, 16'd1);
      tbl[11] = mk(0, 32'h0,        1, 1, 0, 1, 8'hB2, 0, 1, 16'd1);
      tbl[12] = mk(0, 32'h0,        1, 1, 0, 1, 8'hC3, 0, 1, 16'd1);
      tbl[13] = mk(0, 32'h0,        1, 1, 0, 1, 8'hD4, 1, 1, 16'd1);
      tbl[14] = mk(0, 32'h0,        1, 1, 0, 0, 8'h00, 0, 0, 16'd2);
      tbl[15] = mk(1, 32'h11223344, 1, 1, 1, 0, 8'h00, 0, 0, 16'd2);
      tbl[16] = mk(1, 32'h55667788, 1, 1, 0, 1, 8'h11, 0, 1, 16'd2);
      tbl[17] = mk(0, 32'h0,        1, 1, 0, 1, 8'h22, 0, 1, 16'd2);
      tbl[18] = mk(0, 32'h0,        1, 1, 0, 1, 8'h33, 0, 1, 16'd2);
      tbl[19] = mk(0, 32'h0,        1, 1, 1, 1, 8'h44, 1, 1, 16'd2);
      tbl[20] = mk(0, 32'h0,        1, 1, 0, 1, 8'h55, 0, 1, 16'd3);
      tbl[21] = mk(0, 32'h0,        1, 1, 0, 1, 8'h66, 0, 1, 16'd3);
      tbl[22] = mk(0, 32'h0,        1, 1, 0, 1, 8'h77, 0, 1, 16'd3);
      tbl[23] = mk(0, 32'h0,        1, 1, 0, 1, 8'h88, 1, 1, 16'd3);
      tbl[24] = mk(0, 32'h0,        1, 1, 0, 0, 8'h00, 0, 0, 16'd4);
      for (int i = 0; i < 25; i++) begin
         tag = $sformatf("row%0d", i);
         run_row(tbl[i]);
      end

      // Reset after beat 2 accepted; next word must start cleanly at beat 0.
      tag = "mid_a"; run_row(mk(1, 32'h01020304, 1, 1, 1, 0, 8'h00, 0, 0, 16'd4));
      tag = "mid_b"; run_row(mk(0, 32'h0,        1, 1, 0, 1, 8'h01, 0, 1, 16'd4));
      tag = "mid_c"; run_row(mk(0, 32'h0,        1, 1, 0, 1, 8'h02, 0, 1, 16'd4));
      tag = "mid_d"; run_row(mk(1, 32'h0A0B0C0D, 0, 1, 0, 1, 8'h03, 0, 1, 16'd4));
      tag = "mid_e"; run_row(mk(0, 32'h0,        1, 1, 1, 0, 8'h00, 0, 0, 16'd0));
      tag = "mid_f"; run_row(mk(0, 32'h0,        1, 1, 0, 1, 8'h0A, 0, 1, 16'd0));
      tag = "mid_g"; run_row(mk(0, 32'h0,        1, 1, 0, 1, 8'h0B, 0, 1, 16'd0));
      tag = "mid_h"; run_row(mk(0, 32'h0,        1, 1, 0, 1, 8'h0C, 0, 1, 16'd0));
      tag = "mid_i"; run_row(mk(0, 32'h0,        1, 1, 0, 1, 8'h0D, 1, 1, 16'd0));
      tag = "mid_j"; run_row(mk(0, 32'h0,        1, 1, 0, 0, 8'h00, 0, 0, 16'd1));

      // LSB-first instance: 0x000000F7 -> F7,00,00,00.
      lsb_exp[0] = 8'hF7; lsb_exp[1] = 8'h00; lsb_exp[2] = 8'h00; lsb_exp[3] = 8'h00;
      tag = "lsb_pop";
      fifo_empty2 = 1'b0;
      fifo_data2  = 32'h000000F7;
      @(negedge clock);
      chk("fifo_re", {31'b0, fifo_re2}, 32'd1);
      chk("ser_valid", {31'b0, ser_valid2}, 32'd0);
      @(posedge clock);
      #1;
      fifo_empty2 = 1'b1;
      fifo_data2  = '0;
      for (int i = 0; i < 4; i++) begin
         tag = $sformatf("lsb_beat%0d", i);
         @(negedge clock);
         chk("ser_valid", {31'b0, ser_valid2}, 32'd1);
         chk("ser_data", {24'b0, ser_data2}, {24'b0, lsb_exp[i]});
         chk("ser_last", {31'b0, ser_last2}, (i == 3) ? 32'd1 : 32'd0);
         chk("fifo_re", {31'b0, fifo_re2}, 32'd0);
`ifdef SER_PARITY_EN
         chk("ser_parity", {31'b0, ser_parity2}, (i == 0) ? 32'd1 : 32'd0);
`endif
         @(posedge clock);
         #1;
      end
      tag = "lsb_done";
      @(negedge clock);
      chk("ser_valid", {31'b0, ser_valid2}, 32'd0);
      chk("word_cnt", {16'b0, word_cnt2}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
